// File: rtl/cpu_controller_if.sv
// cpu_controller_if: bundles the control unit's bus toward instruction
// memory, register file, ALU and data memory.
// Ports: start/instruction flow into the controller; PC, IR and every
// strobe/select flow out. master = controller, slave = surrounding datapath.
interface cpu_controller_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic [31:0]       instruction;
   logic              im_read;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       ir_out;
   logic              rf_enable;
   logic              rf_read;
   logic              rf_write;
   logic              alu_enable;
   logic              imm_sel;
   logic              wb_sel;
   logic              dm_read;
   logic              dm_write;
   logic              busy;
   logic              illegal;

   modport master (
      input  start, instruction,
      output im_read, im_addr, ir_out,
      output rf_enable, rf_read, rf_write,
      output alu_enable, imm_sel, wb_sel,
      output dm_read, dm_write, busy, illegal
   );

   modport slave (
      output start, instruction,
      input  im_read, im_addr, ir_out,
      input  rf_enable, rf_read, rf_write,
      input  alu_enable, imm_sel, wb_sel,
      input  dm_read, dm_write, busy, illegal
   );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle control FSM (fetch, decode, exec, mem, wb)
// holding PC and IR; all outputs are Moore-decoded from state and IR class.
// Ports: clk, rst (async, active high), bus (cpu_controller_if.master):
// start/instruction in; im_read, im_addr, ir_out, rf_*, alu_enable,
// imm_sel, wb_sel, dm_*, busy, illegal out.
module cpu_controller #(
   parameter int ADDR_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   cpu_controller_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_LOAD_IR = 3'd2,
      S_DECODE  = 3'd3,
      S_EXEC    = 3'd4,
      S_MEM     = 3'd5,
      S_WB      = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      C_ALUR,
      C_ALUI,
      C_LWI,
      C_SWI,
      C_J,
      C_ILL
   } cls_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic              ill_q, ill_d;
   cls_e              cls;

   // Jump offset: sign-extended 24-bit half-word offset, cut to PC width
   logic [ADDR_W+24:0] j_ext;
   logic [ADDR_W-1:0]  j_off;

   assign j_ext = {{ADDR_W{ir_q[23]}}, ir_q[23:0], 1'b0};
   assign j_off = j_ext[ADDR_W-1:0];

   // Instruction class; bit 31 set makes any opcode illegal
   always_comb begin
      cls = C_ILL;
      if (!ir_q[31]) begin
         case (ir_q[30:25])
            6'b100000: cls = C_ALUR;
            6'b101000,
            6'b101100,
            6'b101011,
            6'b100010: cls = C_ALUI;
            6'b000010: cls = C_LWI;
            6'b001010: cls = C_SWI;
            6'b100100: cls = C_J;
            default:   cls = C_ILL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ill_q   <= ill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ill_d   = ill_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_LOAD_IR;
         end
         S_LOAD_IR: begin
            ir_d    = bus.instruction;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (cls == C_ILL) begin
               ill_d   = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cls == C_J)
               state_d = S_FETCH;
            else if (cls == C_LWI || cls == C_SWI)
               state_d = S_MEM;
            else
               state_d = S_WB;
         end
         S_MEM: begin
            state_d = (cls == C_LWI) ? S_WB : S_FETCH;
         end
         S_WB: begin
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Any entry into FETCH other than from IDLE retires an instruction
      if (state_q != S_IDLE && state_d == S_FETCH) begin
         if (cls == C_J)
            pc_d = pc_q + j_off;
         else
            pc_d = pc_q + ADDR_W'(4);
      end
   end

   logic im_read, rf_enable, rf_read, rf_write;
   logic alu_enable, imm_sel, wb_sel;
   logic dm_read, dm_write;

   always_comb begin
      im_read    = 1'b0;
      rf_enable  = 1'b0;
      rf_read    = 1'b0;
      rf_write   = 1'b0;
      alu_enable = 1'b0;
      imm_sel    = 1'b0;
      wb_sel     = 1'b0;
      dm_read    = 1'b0;
      dm_write   = 1'b0;
      unique case (state_q)
         S_FETCH,
         S_LOAD_IR: begin
            im_read = 1'b1;
         end
         S_DECODE: begin
            rf_enable = 1'b1;
            rf_read   = 1'b1;
         end
         S_EXEC: begin
            alu_enable = (cls != C_J) && (cls != C_ILL);
            imm_sel    = (cls == C_ALUI) || (cls == C_LWI)
                         || (cls == C_SWI);
         end
         S_MEM: begin
            dm_read  = (cls == C_LWI);
            dm_write = (cls == C_SWI);
         end
         S_WB: begin
            rf_enable = 1'b1;
            rf_write  = 1'b1;
            wb_sel    = (cls == C_LWI);
         end
         default: begin
            im_read = 1'b0;
         end
      endcase
   end

   assign bus.im_read    = im_read;
   assign bus.im_addr    = pc_q;
   assign bus.ir_out     = ir_q;
   assign bus.rf_enable  = rf_enable;
   assign bus.rf_read    = rf_read;
   assign bus.rf_write   = rf_write;
   assign bus.alu_enable = alu_enable;
   assign bus.imm_sel    = imm_sel;
   assign bus.wb_sel     = wb_sel;
   assign bus.dm_read    = dm_read;
   assign bus.dm_write   = dm_write;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.illegal    = ill_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed instruction sequence for cpu_controller,
// checking strobe timing, PC arithmetic, illegal flag and async reset.
module tb_cpu_controller;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   cpu_controller_if #(.ADDR_W(AW)) bus ();

   cpu_controller #(.ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   // Entered at the negedge of a FETCH cycle; returns at the next FETCH.
   // Cycle indices are 1-based from FETCH, 0 means never seen.
   task automatic run(input string tag, input logic [31:0] instr,
                      input int e_cyc, input int e_rd, input int e_alu,
                      input int e_wr, input int e_imm, input int e_dmr,
                      input int e_dmw, input int e_wbs,
                      input int e_pc, input int e_npc);
      int rd_at = 0, alu_at = 0, wr_at = 0;
      int imm = 0, dmr = 0, dmw = 0, wbs = 0, ovl = 0, n = 0;
      bit done = 1'b0;
      bus.instruction = instr;
      chk({tag, ".pc"}, 32'(bus.im_addr), e_pc);
      for (int k = 0; k < 12; k++) begin
         if (k >= 2 && bus.im_read) begin
            done = 1'b1;
            n = k;
            break;
         end
         if (bus.rf_read && rd_at == 0) rd_at = k + 1;
         if (bus.alu_enable && alu_at == 0) alu_at = k + 1;
         if (bus.rf_write && wr_at == 0) wr_at = k + 1;
         if (bus.imm_sel) imm = 1;
         if (bus.dm_read) dmr = 1;
         if (bus.dm_write) dmw = 1;
         if (bus.wb_sel) wbs = 1;
         if ((bus.rf_read && bus.rf_write) ||
             (bus.dm_read && bus.dm_write)) ovl = 1;
         @(negedge clk);
      end
      chk({tag, ".done"}, 32'(done), 1);
      chk({tag, ".cyc"}, n, e_cyc);
      chk({tag, ".rd"}, rd_at, e_rd);
      chk({tag, ".alu"}, alu_at, e_alu);
      chk({tag, ".wr"}, wr_at, e_wr);
      chk({tag, ".imm"}, imm, e_imm);
      chk({tag, ".dmr"}, dmr, e_dmr);
      chk({tag, ".dmw"}, dmw, e_dmw);
      chk({tag, ".wbs"}, wbs, e_wbs);
      chk({tag, ".ovl"}, ovl, 0);
      chk({tag, ".ir"}, bus.ir_out, instr);
      chk({tag, ".npc"}, 32'(bus.im_addr), e_npc);
   endtask

   function automatic logic [31:0] strobes();
      return {21'd0, bus.im_read, bus.rf_enable, bus.rf_read,
              bus.rf_write, bus.alu_enable, bus.imm_sel, bus.wb_sel,
              bus.dm_read, bus.dm_write, bus.busy, bus.illegal};
   endfunction

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.instruction = '0;
      #2;
      chk("rst.strobes", strobes(), 0);
      chk("rst.pc", 32'(bus.im_addr), 0);
      chk("rst.ir", bus.ir_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle.busy", 32'(bus.busy), 0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start.im_read", 32'(bus.im_read), 1);
      chk("start.busy", 32'(bus.busy), 1);

      //   tag       instr          cyc rd alu wr imm dmr dmw wbs  pc   npc
      run("alur",   32'h40000000, 5, 3, 4, 5, 0, 0, 0, 0,    0,    4);
      run("alui",   32'h50000005, 5, 3, 4, 5, 1, 0, 0, 0,    4,    8);
      run("j_back", 32'h48FFFFFC, 4, 3, 0, 0, 0, 0, 0, 0,    8,    0);
      run("lwi",    32'h04000000, 6, 3, 4, 6, 1, 1, 0, 1,    0,    4);
      run("swi",    32'h14000000, 5, 3, 4, 0, 1, 0, 1, 0,    4,    8);
      chk("ill.pre", 32'(bus.illegal), 0);
      run("ill",    32'h7E000000, 3, 3, 0, 0, 0, 0, 0, 0,    8,   12);
      chk("ill.set", 32'(bus.illegal), 1);
      run("ill31",  32'hC0000000, 3, 3, 0, 0, 0, 0, 0, 0,   12,   16);
      run("j_fwd",  32'h480001F6, 4, 3, 0, 0, 0, 0, 0, 0,   16, 1020);
      run("wrap",   32'h58000000, 5, 3, 4, 5, 1, 0, 0, 0, 1020,    0);
      run("alui2",  32'h56000000, 5, 3, 4, 5, 1, 0, 0, 0,    0,    4);
      run("alui3",  32'h44000000, 5, 3, 4, 5, 1, 0, 0, 0,    4,    8);
      chk("ill.sticky", 32'(bus.illegal), 1);

      bus.instruction = 32'h40000000;
      repeat (4) @(negedge clk);
      chk("mid.wb", 32'(bus.rf_write), 1);
      #1 rst = 1'b1;
      #1;
      chk("mid.strobes", strobes(), 0);
      chk("mid.ir", bus.ir_out, 0);
      chk("mid.pc", 32'(bus.im_addr), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid.idle", strobes(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle control unit that sequences each instruction through fetch, register read, execute, memory and write-back. Holds the PC and the instruction register. Drives the register file's `enable`/`Read`/`Write` strobes and its `instruction` port, plus the ALU, instruction-memory and data-memory strobes. It sits directly upstream of the register file and guarantees that Read and Write are never asserted in the same cycle.

## Interface
- `ADDR_W`, 10: instruction-memory byte-address width; the PC wraps modulo 2^ADDR_W.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: leaves IDLE when high in IDLE; ignored in every other state.
- `instruction` in 32: instruction-memory read data, valid in LOAD_IR.
- `im_read` out 1: instruction-memory read strobe.
- `im_addr` out ADDR_W: always equals PC.
- `ir_out` out 32: instruction register; drives the register-file `instruction` port.
- `rf_enable` out 1: register-file enable.
- `rf_read` out 1: register-file read.
- `rf_write` out 1: register-file write.
- `alu_enable` out 1: ALU operation strobe.
- `imm_sel` out 1: selects the ALU B operand. 1 = immediate, 0 = `out_2`.
- `wb_sel` out 1: selects write-back data. 0 = ALU, 1 = data memory.
- `dm_read` out 1: data-memory read.
- `dm_write` out 1: data-memory write.
- `busy` out 1: high in every state except IDLE.
- `illegal` out 1: sticky; set on an unsupported opcode, cleared only by `rst`.

## Operation
- **Decode fields.** Opcode is `ir[30:25]`. `ir[31]` must be 0; otherwise the instruction is illegal.
- **Opcode classes:**
  - ALU-R: 100000.
  - ALU-I: 101000, 101100, 101011, 100010.
  - LWI: 000010.
  - SWI: 001010.
  - J: 100100.
  - Any other opcode is illegal.
- **Illegal instruction.** Set `illegal`. Execute as a NOP: DECODE is followed directly by the PC update and FETCH.
- **States.** IDLE, FETCH, LOAD_IR, DECODE, EXEC, MEM, WB. State register is binary encoded.
- **All outputs are Moore outputs** decoded from the state and the IR class.
- **IDLE**
  - All strobes low.
  - Goes to FETCH when `start`=1.
- **FETCH**
  - `im_read`=1.
  - Goes to LOAD_IR.
- **LOAD_IR**
  - `im_read`=1.
  - `ir <= instruction` on exit.
  - Goes to DECODE.
- **DECODE**
  - `rf_enable`=1, `rf_read`=1.
  - Goes to EXEC, or to FETCH if the instruction is illegal.
- **EXEC**
  - `alu_enable`=1 for ALU-R, ALU-I, LWI and SWI.
  - `imm_sel`=1 for ALU-I, LWI and SWI.
  - Next state: ALU classes go to WB; LWI and SWI go to MEM; J goes to FETCH.
- **MEM**
  - LWI: `dm_read`=1, then WB.
  - SWI: `dm_write`=1, then FETCH.
- **WB**
  - `rf_enable`=1, `rf_write`=1.
  - `wb_sel`=1 for LWI, 0 otherwise.
  - Goes to FETCH.
- **PC update.** Occurs on the edge leaving the last state of each instruction (any transition into FETCH).
  - J: `pc <= pc + {sext(ir[23:0]),1'b0}`, truncated to ADDR_W bits.
  - All other instructions: `pc <= pc + 4`, wrapping at 2^ADDR_W.
- **Exclusivity.** `rf_read` and `rf_write` are never high in the same cycle. Likewise `dm_read` and `dm_write`.

## Timing
- **Reset values.** While `rst`=1, immediately and independent of `clk`:
  - state = IDLE, PC = 0, `ir_out` = 0, `illegal` = 0.
  - Every strobe and select = 0; `busy` = 0.
- **Reset mid-instruction.** Abort with no further strobes. No register or memory write completes after `rst` rises.
- **Cycles per instruction, counted from FETCH:**
  - ALU-R / ALU-I: 5.
  - LWI: 6.
  - SWI: 5.
  - J: 4.
  - Illegal: 3.
- **Start latency.** `start` sampled high in IDLE gives FETCH in the next cycle.
- **Free-running.** The FSM never returns to IDLE except by reset.
- **IR stability.** `ir_out` is stable from DECODE through the final state of the instruction. The register file therefore sees constant addresses during both read and write.
- **Register-file read data.** `out_1`, `out_2` and `out_3` are registered by the register file at the end of DECODE and are valid in EXEC.

## Test plan
- **Reset then start.** Assert `rst`, release it, pulse `start`.
  - All outputs are 0 during reset.
  - `im_addr`=0 and `im_read`=1 in the cycle after `start`.
- **ALU-R then ALU-I.** Instructions 0x40000000 then 0x50000005.
  - Each takes 5 cycles.
  - `rf_read` in cycle 3, `alu_enable` in cycle 4, `rf_write` in cycle 5.
  - `imm_sel` = 0 for the first and 1 for the second.
  - PC goes 0 → 4 → 8.
- **LWI then SWI.** Opcodes 000010 and 001010.
  - LWI: 6 cycles, `dm_read` in MEM, `wb_sel`=1 in WB.
  - SWI: 5 cycles, `dm_write` in MEM, `rf_write` never asserted.
- **J wrap-around.** PC=8, J with `ir[23:0]`=0xFFFFFC (−4).
  - Next PC = 8 − 8 = 0.
  - PC=1020 with a non-jump instruction gives next PC 0.
- **Illegal opcode.** Execute 0x7E000000.
  - `illegal` goes to 1 and stays 1.
  - No `alu_enable`, `dm_*` or `rf_write` strobes; 3 cycles; PC += 4.
- **Mid-write reset.** Assert `rst` in WB.
  - `rf_write` drops in the same cycle; state returns to IDLE.
  - `rf_read` and `rf_write` are never both high in any cycle of any test.
